// File: rtl/week04_first.sv
// Purpose : D-type register / retiming cell, STAGES deep and WIDTH wide, async active-low reset.
// Latency : Din sampled at rising edge k is on Qout after edge k+STAGES-1 (STAGES=1: right after edge k).
// Backpr. : none; every rising edge with RST=1 captures Din and shifts the chain.
//
// Ports:
//   CLK  - clock, all state changes on the rising edge
//   RST  - asynchronous reset, active-low; loads RESET_VALUE into every stage
//   Din  - WIDTH-bit data input, sampled on the rising edge
//   Qout - WIDTH-bit output, driven straight from the last stage (no Din->Qout comb path)
module week04_first #(
    parameter int                 WIDTH       = 1,
    parameter int                 STAGES      = 1,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] Din,
    output logic [WIDTH-1:0] Qout
);

    // r_stage[0] is nearest Din, r_stage[STAGES-1] feeds Qout.
    logic [WIDTH-1:0] r_stage [STAGES];

    // Reset clears the whole chain at once, so in-flight data is discarded
    // rather than partially shifted out.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < STAGES; i++) begin
                r_stage[i] <= RESET_VALUE;
            end
        end else begin
            r_stage[0] <= Din;
            for (int i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign Qout = r_stage[STAGES-1];

endmodule

// File: tb/tb_week04_first.sv
module tb_week04_first;

    logic       CLK;
    logic       RST;
    logic       din1;
    logic       q1;
    logic [3:0] din4;
    logic [3:0] q4;

    int checks;
    int errors;

    // Single-stage, 1-bit cell (default parameters).
    week04_first u_dut1 (
        .CLK  (CLK),
        .RST  (RST),
        .Din  (din1),
        .Qout (q1)
    );

    // Three-stage, 4-bit chain.
    week04_first #(
        .WIDTH       (4),
        .STAGES      (3),
        .RESET_VALUE (4'h0)
    ) u_dut3 (
        .CLK  (CLK),
        .RST  (RST),
        .Din  (din4),
        .Qout (q4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST  = 1'b0;
        din1 = 1'b1;
        din4 = 4'hF;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (q1 !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold_q1 edge %0d: got %b expected 0", i, q1);
            end
            checks++;
            if (q4 !== 4'h0) begin
                errors++;
                $display("FAIL reset_hold_q4 edge %0d: got %h expected 0", i, q4);
            end
        end
    endtask

    task automatic test_capture();
        din4 = 4'h0;
        RST  = 1'b1;
        din1 = 1'b1;
        tick();
        checks++;
        if (q1 !== 1'b1) begin
            errors++;
            $display("FAIL capture_one: got %b expected 1", q1);
        end
        @(negedge CLK);
        #1;
        checks++;
        if (q1 !== 1'b1) begin
            errors++;
            $display("FAIL falling_edge_hold: got %b expected 1", q1);
        end
        din1 = 1'b0;
        #1;
        checks++;
        if (q1 !== 1'b1) begin
            errors++;
            $display("FAIL midcycle_din_change: got %b expected 1", q1);
        end
        tick();
        checks++;
        if (q1 !== 1'b0) begin
            errors++;
            $display("FAIL capture_zero: got %b expected 0", q1);
        end
    endtask

    task automatic test_glitch();
        din1 = 1'b0;
        @(negedge CLK);
        din1 = 1'b1;
        #1;
        din1 = 1'b0;
        #1;
        checks++;
        if (q1 !== 1'b0) begin
            errors++;
            $display("FAIL glitch_between_edges: got %b expected 0", q1);
        end
        tick();
        checks++;
        if (q1 !== 1'b0) begin
            errors++;
            $display("FAIL glitch_after_edge: got %b expected 0", q1);
        end
    endtask

    task automatic test_async_reset();
        din1 = 1'b1;
        tick();
        checks++;
        if (q1 !== 1'b1) begin
            errors++;
            $display("FAIL async_preload: got %b expected 1", q1);
        end
        #2;
        RST = 1'b0;
        #1;
        checks++;
        if (q1 !== 1'b0) begin
            errors++;
            $display("FAIL async_assert_immediate: got %b expected 0", q1);
        end
        #1;
        RST = 1'b1;
        tick();
        checks++;
        if (q1 !== 1'b1) begin
            errors++;
            $display("FAIL async_release_capture: got %b expected 1", q1);
        end
    endtask

    task automatic test_coincident_release();
        RST  = 1'b0;
        din1 = 1'b1;
        @(posedge CLK);
        #0 RST = 1'b1;
        #1;
        checks++;
        if (q1 !== 1'b0) begin
            errors++;
            $display("FAIL coincident_release_edge: got %b expected 0", q1);
        end
        tick();
        checks++;
        if (q1 !== 1'b1) begin
            errors++;
            $display("FAIL coincident_release_next: got %b expected 1", q1);
        end
    endtask

    task automatic test_coincident_assert();
        din1 = 1'b1;
        @(posedge CLK);
        #0 RST = 1'b0;
        #1;
        checks++;
        if (q1 !== 1'b0) begin
            errors++;
            $display("FAIL coincident_assert: got %b expected 0", q1);
        end
        #2;
        RST  = 1'b1;
        din1 = 1'b0;
    endtask

    task automatic test_pipeline();
        RST  = 1'b0;
        din1 = 1'b0;
        din4 = 4'h0;
        #2;
        RST = 1'b1;
        tick();
        tick();
        din4 = 4'hA;
        tick();                             // edge k
        checks++;
        if (q4 !== 4'h0) begin
            errors++;
            $display("FAIL pipe_edge_k: got %h expected 0", q4);
        end
        din4 = 4'h0;
        tick();                             // edge k+1
        checks++;
        if (q4 !== 4'h0) begin
            errors++;
            $display("FAIL pipe_edge_k1: got %h expected 0", q4);
        end
        tick();                             // edge k+2
        checks++;
        if (q4 !== 4'hA) begin
            errors++;
            $display("FAIL pipe_edge_k2: got %h expected a", q4);
        end
        tick();                             // edge k+3
        checks++;
        if (q4 !== 4'h0) begin
            errors++;
            $display("FAIL pipe_edge_k3: got %h expected 0", q4);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] vin [8];
        logic [3:0] vexp [8];
        vin  = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h0, 4'h0};
        vexp = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
        for (int j = 0; j < 8; j++) begin
            din4 = vin[j];
            tick();
            checks++;
            if (q4 !== vexp[j]) begin
                errors++;
                $display("FAIL back_to_back edge %0d: got %h expected %h", j, q4, vexp[j]);
            end
        end
    endtask

    task automatic test_reset_flush();
        din4 = 4'h7;
        tick();
        din4 = 4'h8;
        tick();
        din4 = 4'h9;
        tick();
        checks++;
        if (q4 !== 4'h7) begin
            errors++;
            $display("FAIL flush_preload: got %h expected 7", q4);
        end
        #1;
        RST = 1'b0;
        #1;
        checks++;
        if (q4 !== 4'h0) begin
            errors++;
            $display("FAIL flush_assert: got %h expected 0", q4);
        end
        din4 = 4'h0;
        #1;
        RST = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            checks++;
            if (q4 !== 4'h0) begin
                errors++;
                $display("FAIL flush_residue edge %0d: got %h expected 0", j, q4);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RST    = 1'b0;
        din1   = 1'b0;
        din4   = 4'h0;
        test_reset();
        test_capture();
        test_glitch();
        test_async_reset();
        test_coincident_release();
        test_coincident_assert();
        test_pipeline();
        test_back_to_back();
        test_reset_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
